card_dealer: RTL and testbench
==============================

# card_dealer

Draws cards without replacement from a single 52-card deck for the Blackjack engine. Sits directly downstream of the 6-bit LFSR random source (`rand6`). It turns the raw random stream into dealt cards by rejection sampling against a dealt-card mask. It serves one card per request to the hand/score logic over a request/valid handshake.

## Interface
- `DECK_SIZE`, 52: number of distinct cards; card index range 0..DECK_SIZE-1.
- `RAND_W`, 6: width of the random input; 2^RAND_W-1 must be ≥ DECK_SIZE.
- `clock_in` in 1: single clock; all state on rising edge.
- `reset_in` in 1: asynchronous, active-low reset.
- `rand_in` in RAND_W: raw LFSR state, one new nonzero value per clock.
- `shuffle_in` in 1: one-cycle pulse; returns all cards to the deck.
- `deal_req_in` in 1: request one card; sampled only in IDLE.
- `card_out` out 6: dealt card index, suit = index/13, rank = index%13.
- `rank_out` out 4: 1 = Ace .. 13 = King.
- `value_out` out 4: Blackjack value; 2..9 face value, 10 for ranks 10..13, 1 for Ace.
- `is_ace_out` out 1: dealt card is an Ace.
- `card_valid_out` out 1: one-cycle pulse; card outputs are valid.
- `empty_err_out` out 1: one-cycle pulse; request arrived with the deck empty.
- `busy_out` out 1: high whenever state ≠ IDLE.
- `cards_left_out` out 6: cards remaining, 0..52.

## Operation
- States:
  - IDLE: waits for requests.
  - DRAW: samples `rand_in` every cycle.
  - EMPTY_ERR: single cycle; raises the empty error.
- Candidate index = `rand_in` − 1, giving 0..62. The −1 maps the LFSR's nonzero range so that card 0 is reachable.
- DRAW hit: candidate < DECK_SIZE and its mask bit is clear.
  - Set the mask bit, decrement `cards_left_out`.
  - Register the card outputs, pulse `card_valid_out`, go to IDLE.
- DRAW miss: stay in DRAW and retry on the next cycle's `rand_in`.
- IDLE with `deal_req_in`=1:
  - `cards_left_out`>0 → DRAW.
  - `cards_left_out`=0 → EMPTY_ERR, which pulses `empty_err_out` and returns to IDLE.
- `shuffle_in` takes priority in every state:
  - Clears the mask and sets `cards_left_out`=52.
  - Aborts any draw in progress, with no valid pulse and no mask change.
  - Next state is IDLE.
- `shuffle_in` and `deal_req_in` in the same IDLE cycle: shuffle wins and the request is dropped. The requester must re-assert.
- `deal_req_in` outside IDLE is ignored; no queueing.
- `card_out`, `rank_out`, `value_out` and `is_ace_out` hold the last dealt card until the next hit.
- Reset values:
  - State IDLE, mask clear, `cards_left_out`=52.
  - `card_out`=0, `rank_out`=0, `value_out`=0.
  - `is_ace_out`, `card_valid_out`, `empty_err_out`, `busy_out` all 0.

## Timing
- Request sampled at edge k. The first DRAW sample is at edge k+1.
- Minimum latency: `card_valid_out` high in the cycle after edge k+1, i.e. 2 clocks from request to valid.
- Worst case: a maximal-length 6-bit LFSR visits all 63 nonzero states in 63 cycles. Any remaining card is therefore found within 63 DRAW cycles, for a 64-clock bound.
- `empty_err_out` is high exactly one cycle, the cycle after the request edge.
- `cards_left_out` updates in the same cycle that `card_valid_out` rises.
- Reset asserted mid-DRAW: outputs go to reset values immediately (asynchronously). No pulse is emitted.

## Structure
- `blackjack_pkg` holds:
  - `DECK_SIZE`, `NUM_RANKS`=13, `CARD_W`=6.
  - The state enum (IDLE/DRAW/EMPTY_ERR).
  - The card-value constants.
- Sub-module `card_decode`: purely combinational, index → rank, value, is_ace. Implemented as a subtract-by-13 chain, no divider. Its output is registered in `card_dealer` on a hit.
- The 52-bit mask and the 6-bit counter live in `card_dealer`.

## Test plan
- Reset then one request, with `rand_in`=1: card 0 is dealt; `rank_out`=1, `value_out`=1, `is_ace_out`=1, `cards_left_out`=51, valid 2 clocks after the request.
- `rand_in`=53..63 for 3 cycles, then 24: 3 misses, then card 23 (rank 11, value 10), valid 5 clocks after the request.
- Deal card 5, then drive `rand_in`=6 again followed by 7: the repeat is rejected and card 6 is dealt.
- Drive `rand_in` from a real `rand6` (seed 6'b101010) for 52 requests: 52 distinct indices, each within 64 clocks, `cards_left_out`=0. A 53rd request gives `empty_err_out` pulsed, no valid.
- `shuffle_in` mid-DRAW, and `shuffle_in` together with `deal_req_in` in IDLE: no valid in either case, `cards_left_out`=52, mask cleared (card 0 dealable again).
- Reset asserted during DRAW: all outputs at reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared constants and types for the Blackjack card path.
// Deck geometry, dealer states and card value encoding.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;
    localparam int CARD_W    = 6;
    localparam int RANK_W    = 4;

    localparam logic [3:0] ACE_VALUE     = 4'd1;
    localparam logic [3:0] FACE_VALUE    = 4'd10;
    localparam logic [3:0] FACE_MIN_RANK = 4'd10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAW      = 2'd1,
        EMPTY_ERR = 2'd2
    } dealer_state_e;

    typedef struct packed {
        logic [RANK_W-1:0] rank;
        logic [3:0]        value;
        logic              is_ace;
    } card_info_t;

endpackage

// File: rtl/card_decode.sv
// Card index to rank/value/ace, using a subtract-by-13 chain instead of a divider.
// Purely combinational; the dealer registers the result on a hit.
module card_decode
    import blackjack_pkg::*;
(
    input  logic [CARD_W-1:0] card_in,
    output card_info_t        info_out
);

    logic [CARD_W-1:0] rem;
    logic [RANK_W-1:0] rank;

    // Four stages cover every 6-bit index, including the unused 52..63.
    always_comb begin
        rem = card_in;
        for (int i = 0; i < 4; i++) begin
            if (rem >= CARD_W'(NUM_RANKS)) begin
                rem = rem - CARD_W'(NUM_RANKS);
            end
        end
    end

    always_comb begin
        rank            = RANK_W'(rem) + RANK_W'(1);
        info_out.rank   = rank;
        info_out.is_ace = (rem == '0);
        if (rem == '0) begin
            info_out.value = ACE_VALUE;
        end else if (rank >= FACE_MIN_RANK) begin
            info_out.value = FACE_VALUE;
        end else begin
            info_out.value = rank;
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Draws cards without replacement by rejection-sampling the LFSR stream
// against a dealt-card mask; one card per request.
module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int RAND_W    = 6
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              shuffle_in,
    input  logic              deal_req_in,
    output logic [5:0]        card_out,
    output logic [3:0]        rank_out,
    output logic [3:0]        value_out,
    output logic              is_ace_out,
    output logic              card_valid_out,
    output logic              empty_err_out,
    output logic              busy_out,
    output logic [5:0]        cards_left_out
);
    import blackjack_pkg::*;

    dealer_state_e         state_q, state_d;
    logic [DECK_SIZE-1:0]  mask_q, mask_d;
    logic [CARD_W-1:0]     cards_left_q, cards_left_d;
    logic [CARD_W-1:0]     card_q, card_d;
    card_info_t            info_q, info_d;
    logic                  valid_q, valid_d;

    logic [RAND_W-1:0]     cand;
    logic [CARD_W-1:0]     cand_card;
    logic [DECK_SIZE-1:0]  hit_vec;
    logic                  taken;
    logic                  hit;
    card_info_t            dec_info;

    // LFSR never yields 0, so subtract one to make card 0 reachable.
    assign cand      = rand_in - RAND_W'(1);
    assign cand_card = CARD_W'(cand);

    // Out-of-range candidates match no mask bit and read as taken.
    always_comb begin
        taken   = 1'b1;
        hit_vec = '0;
        for (int i = 0; i < DECK_SIZE; i++) begin
            if (cand == RAND_W'(i)) begin
                taken      = mask_q[i];
                hit_vec[i] = 1'b1;
            end
        end
    end

    assign hit = !taken;

    card_decode u_decode (
        .card_in  (cand_card),
        .info_out (dec_info)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cards_left_d = cards_left_q;
        card_d       = card_q;
        info_d       = info_q;
        valid_d      = 1'b0;
        if (shuffle_in) begin
            state_d      = IDLE;
            mask_d       = '0;
            cards_left_d = CARD_W'(DECK_SIZE);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (deal_req_in) begin
                        if (cards_left_q == '0) begin
                            state_d = EMPTY_ERR;
                        end else begin
                            state_d = DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (hit) begin
                        state_d      = IDLE;
                        mask_d       = mask_q | hit_vec;
                        cards_left_d = cards_left_q - CARD_W'(1);
                        card_d       = cand_card;
                        info_d       = dec_info;
                        valid_d      = 1'b1;
                    end
                end
                EMPTY_ERR: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            cards_left_q <= CARD_W'(DECK_SIZE);
            card_q       <= '0;
            info_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cards_left_q <= cards_left_d;
            card_q       <= card_d;
            info_q       <= info_d;
            valid_q      <= valid_d;
        end
    end

    assign card_out       = card_q;
    assign rank_out       = info_q.rank;
    assign value_out      = info_q.value;
    assign is_ace_out     = info_q.is_ace;
    assign card_valid_out = valid_q;
    assign empty_err_out  = (state_q == EMPTY_ERR);
    assign busy_out       = (state_q != IDLE);
    assign cards_left_out = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a deck model predicts each dealt card
// from the planned random stream; a negedge monitor checks every pulse.
`timescale 1ns/1ps
module tb_card_dealer;

    logic       clock_in = 1'b0;
    logic       reset_in = 1'b0;
    logic [5:0] rand_in = 6'd1;
    logic       shuffle_in = 1'b0;
    logic       deal_req_in = 1'b0;
    logic [5:0] card_out;
    logic [3:0] rank_out;
    logic [3:0] value_out;
    logic       is_ace_out;
    logic       card_valid_out;
    logic       empty_err_out;
    logic       busy_out;
    logic [5:0] cards_left_out;

    card_dealer dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .rand_in        (rand_in),
        .shuffle_in     (shuffle_in),
        .deal_req_in    (deal_req_in),
        .card_out       (card_out),
        .rank_out       (rank_out),
        .value_out      (value_out),
        .is_ace_out     (is_ace_out),
        .card_valid_out (card_valid_out),
        .empty_err_out  (empty_err_out),
        .busy_out       (busy_out),
        .cards_left_out (cards_left_out)
    );

    always #5 clock_in = ~clock_in;

    int total = 0;
    int bad = 0;
    int edge_n = 0;

    always @(posedge clock_in) edge_n++;

    typedef struct {
        bit err;
        int card;
        int left;
        int lat;
        int req_edge;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    bit dealt[52];
    int left = 52;
    logic [5:0] lfsr = 6'b101010;
    int dir[$];
    int mode = 0;
    logic [5:0] plan[$];
    bit seen[64];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // mode 0: directed list, 1: rand6 LFSR, 2: uniform random nonzero
    function automatic logic [5:0] gen();
        logic [5:0] r;
        if (mode == 0 && dir.size() > 0) begin
            r = 6'(dir.pop_front());
        end else if (mode == 2) begin
            r = 6'($urandom_range(1, 63));
        end else begin
            r = lfsr;
            lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
        end
        return r;
    endfunction

    task automatic step();
        if (plan.size() > 0) rand_in = plan.pop_front();
        else rand_in = gen();
        @(posedge clock_in);
        #1;
    endtask

    task automatic model_shuffle();
        foreach (dealt[i]) dealt[i] = 1'b0;
        left = 52;
    endtask

    task automatic shuffle();
        shuffle_in = 1'b1;
        step();
        shuffle_in = 1'b0;
        model_shuffle();
    endtask

    task automatic request(input int vals[$]);
        exp_t e;
        logic [5:0] r;
        int n;
        int ir;
        bit hit;
        n = 0;
        hit = 1'b0;
        dir = vals;
        deal_req_in = 1'b1;
        e.req_edge = edge_n + 1;
        e.err = (left == 0);
        e.card = 0;
        e.lat = 1;
        e.left = left;
        rand_in = (mode == 0) ? 6'd63 : gen();
        if (!e.err) begin
            plan.delete();
            while (!hit && n < 400) begin
                r = gen();
                plan.push_back(r);
                n++;
                ir = int'(r) - 1;
                if (ir >= 0 && ir < 52 && !dealt[ir]) begin
                    hit = 1'b1;
                    e.card = ir;
                end
            end
            if (hit) begin
                dealt[e.card] = 1'b1;
                left--;
            end
            e.left = left;
            e.lat = n + 1;
            chk("plan_hit", int'(hit), 1);
        end
        if (e.err || hit) sb.push_back(e);
        @(posedge clock_in);
        #1;
        deal_req_in = 1'b0;
        while (plan.size() > 0) step();
        dir.delete();
        step();
        step();
    endtask

    always @(negedge clock_in) begin
        if (reset_in && (card_valid_out || empty_err_out)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", int'(card_valid_out | empty_err_out), 0);
            end else begin
                m = sb.pop_front();
                chk("err_flag", int'(empty_err_out), int'(m.err));
                chk("valid_flag", int'(card_valid_out), int'(!m.err));
                chk("latency", edge_n - m.req_edge + 1, m.lat);
                if (!m.err) begin
                    seen[card_out] = 1'b1;
                    chk("card", int'(card_out), m.card);
                    chk("rank", int'(rank_out), m.card % 13 + 1);
                    chk("value", int'(value_out),
                        (m.card % 13 >= 9) ? 10 : m.card % 13 + 1);
                    chk("is_ace", int'(is_ace_out), int'(m.card % 13 == 0));
                    chk("cards_left", int'(cards_left_out), m.left);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        int cnt;
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_card", int'(card_out), 0);
        chk("rst_rank", int'(rank_out), 0);
        chk("rst_value", int'(value_out), 0);
        chk("rst_ace", int'(is_ace_out), 0);
        chk("rst_valid", int'(card_valid_out), 0);
        chk("rst_err", int'(empty_err_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_left", int'(cards_left_out), 52);
        #2 reset_in = 1'b1;
        @(posedge clock_in);
        #1;

        mode = 0;
        q = '{1};
        request(q);
        q = '{54, 60, 63, 24};
        request(q);
        q = '{6};
        request(q);
        q = '{6, 7};
        request(q);

        // shuffle mid-draw, on an edge where the sample would hit
        deal_req_in = 1'b1;
        rand_in = 6'd60;
        @(posedge clock_in);
        #1;
        deal_req_in = 1'b0;
        chk("busy_draw", int'(busy_out), 1);
        rand_in = 6'd60;
        @(posedge clock_in);
        #1;
        rand_in = 6'd9;
        shuffle_in = 1'b1;
        @(posedge clock_in);
        #1;
        shuffle_in = 1'b0;
        model_shuffle();
        chk("abort_busy", int'(busy_out), 0);
        chk("abort_left", int'(cards_left_out), 52);
        step();
        step();

        // shuffle and request together in IDLE: request dropped
        deal_req_in = 1'b1;
        shuffle_in = 1'b1;
        rand_in = 6'd1;
        @(posedge clock_in);
        #1;
        deal_req_in = 1'b0;
        shuffle_in = 1'b0;
        chk("drop_busy", int'(busy_out), 0);
        plan.push_back(6'd1);
        plan.push_back(6'd1);
        plan.push_back(6'd1);
        step();
        step();
        step();
        chk("drop_left", int'(cards_left_out), 52);
        q = '{1};
        request(q);

        // uniform random stream
        shuffle();
        mode = 2;
        q.delete();
        repeat (15) begin
            repeat ($urandom_range(0, 3)) step();
            request(q);
        end

        // real rand6 stream over a full deck
        shuffle();
        mode = 1;
        lfsr = 6'b101010;
        foreach (seen[i]) seen[i] = 1'b0;
        repeat (52) begin
            repeat ($urandom_range(0, 3)) step();
            request(q);
        end
        cnt = 0;
        foreach (seen[i]) if (seen[i]) cnt++;
        chk("distinct", cnt, 52);
        chk("deck_empty", int'(cards_left_out), 0);
        request(q);
        step();
        chk("after_err_busy", int'(busy_out), 0);

        // asynchronous reset during a draw
        shuffle();
        deal_req_in = 1'b1;
        rand_in = 6'd60;
        @(posedge clock_in);
        #1;
        deal_req_in = 1'b0;
        rand_in = 6'd60;
        @(posedge clock_in);
        #1;
        chk("pre_rst_busy", int'(busy_out), 1);
        rand_in = 6'd9;
        #2 reset_in = 1'b0;
        #1;
        chk("arst_card", int'(card_out), 0);
        chk("arst_rank", int'(rank_out), 0);
        chk("arst_value", int'(value_out), 0);
        chk("arst_ace", int'(is_ace_out), 0);
        chk("arst_valid", int'(card_valid_out), 0);
        chk("arst_busy", int'(busy_out), 0);
        chk("arst_left", int'(cards_left_out), 52);
        @(posedge clock_in);
        #3 reset_in = 1'b1;
        model_shuffle();
        step();
        step();
        chk("post_rst_busy", int'(busy_out), 0);
        chk("post_rst_valid", int'(card_valid_out), 0);

        step();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
